// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode/ALU constants, FSM states and strobe bundle shared by control_sequencer and its decoder.
package cpu_ctrl_pkg;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam logic [4:0] OP_LD = 5'd0, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4, OP_AND = 5'd5, OP_OR = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd12, OP_NOP = 5'd26, OP_HALT = 5'd27;
  localparam logic [4:0] ALU_NONE = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_AND = 5'd3, ALU_OR = 5'd4;
  typedef enum logic [3:0] {S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED} state_t;
  typedef enum logic [2:0] {CL_ALU, CL_ADDI, CL_LD, CL_ST, CL_NOP, CL_HALT} class_t;
  typedef struct packed {
    logic PCout, ZLowout, MDRout, Cout;
    logic MARin, MDRin, IRin, PCin, Yin, Zin;
    logic IncPC, Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0] alu_op;
    logic run;
  } ctrl_t;
  // Undefined opcodes fall into the nop class.
  function automatic class_t op_class(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR} ? CL_ALU :
           op == OP_ADDI ? CL_ADDI : op == OP_LD ? CL_LD : op == OP_ST ? CL_ST :
           op == OP_HALT ? CL_HALT : op == OP_NOP ? CL_NOP : CL_NOP;
  endfunction
  function automatic logic [4:0] alu_code(input logic [4:0] op);
    return op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : op == OP_OR ? ALU_OR : ALU_ADD;
  endfunction
endpackage

// File: rtl/ctrl_output_decode.sv
// ctrl_output_decode: combinational strobe decode from FSM state, opcode and memory completion.
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [4:0] i_opcode,
  input  logic       i_done,
  output ctrl_t      o_ctrl
);
  class_t w_cls;
  logic w_alu, w_ld, w_st, w_calc;
  assign w_cls = op_class(i_opcode);
  assign w_alu = w_cls == CL_ALU || w_cls == CL_ADDI;
  assign w_ld = w_cls == CL_LD;
  assign w_st = w_cls == CL_ST;
  assign w_calc = w_alu | w_ld | w_st;
  always_comb begin
    o_ctrl = '0;
    o_ctrl.run = i_state != S_HALTED;
    case (i_state)
      S_T0: {o_ctrl.PCout, o_ctrl.MARin, o_ctrl.IncPC, o_ctrl.Zin} = 4'b1111;
      S_T1: {o_ctrl.Read, o_ctrl.ZLowout, o_ctrl.PCin, o_ctrl.MDRin} = {3'b111, i_done};
      S_T2: {o_ctrl.MDRout, o_ctrl.IRin} = 2'b11;
      S_T3: {o_ctrl.Grb, o_ctrl.Yin, o_ctrl.Rout, o_ctrl.BAout} = {w_calc, w_calc, w_alu, w_ld | w_st};
      S_T4: begin
        o_ctrl.Zin = w_calc;
        {o_ctrl.Grc, o_ctrl.Rout} = {2{w_cls == CL_ALU}};
        o_ctrl.Cout = w_calc & (w_cls != CL_ALU);
        o_ctrl.alu_op = w_calc ? alu_code(i_opcode) : ALU_NONE;
      end
      S_T5: {o_ctrl.ZLowout, o_ctrl.Gra, o_ctrl.Rin, o_ctrl.MARin} = {w_calc, w_alu, w_alu, w_ld | w_st};
      S_T6: {o_ctrl.Read, o_ctrl.MDRin, o_ctrl.Gra, o_ctrl.Rout} = {w_ld, (w_ld & i_done) | w_st, w_st, w_st};
      S_T7: {o_ctrl.MDRout, o_ctrl.Gra, o_ctrl.Rin, o_ctrl.Write} = {w_ld, w_ld, w_ld, w_st};
      default: ;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute FSM for the single-bus CPU datapath.
// Define CTRL_WAIT_STATES_EN to honour mem_ready; otherwise memory states last one cycle.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            PCout, ZLowout, MDRout, Cout,
  output logic            MARin, MDRin, IRin, PCin, Yin, Zin,
  output logic            IncPC, Read, Write,
  output logic            Gra, Grb, Grc, Rin, Rout, BAout,
  output logic [ALUW-1:0] alu_op,
  output logic            run
);
  state_t r_state;
  ctrl_t w_ctrl;
  class_t w_cls;
  logic [OPW-1:0] w_op;
  logic [4:0] w_alu_op;
  logic w_done, w_hold, w_unused;
  assign w_op = ir[OP_MSB -: OPW];
  assign w_cls = op_class(w_op);
`ifdef CTRL_WAIT_STATES_EN
  assign w_done = mem_ready;
`else
  assign w_done = 1'b1;
`endif
  assign w_unused = &{1'b0, ir[OP_MSB-OPW:0], mem_ready};
  // Memory states stall until the access completes.
  assign w_hold = ~w_done & (r_state == S_T1 || (r_state == S_T6 && w_cls == CL_LD) || (r_state == S_T7 && w_cls == CL_ST));
  always_ff @(posedge clk or posedge clr)
    if (clr) r_state <= S_RST;
    else if (!w_hold)
      case (r_state)
        S_RST: r_state <= S_T0;
        S_T0: r_state <= S_T1;
        S_T1: r_state <= S_T2;
        S_T2: r_state <= S_T3;
        S_T3: r_state <= w_cls == CL_HALT ? S_HALTED : w_cls == CL_NOP ? S_T0 : S_T4;
        S_T4: r_state <= S_T5;
        S_T5: r_state <= (w_cls == CL_ALU || w_cls == CL_ADDI) ? S_T0 : S_T6;
        S_T6: r_state <= S_T7;
        S_T7: r_state <= S_T0;
        default: r_state <= S_HALTED;
      endcase
  ctrl_output_decode u_dec (
    .i_state (r_state),
    .i_opcode(w_op),
    .i_done  (w_done),
    .o_ctrl  (w_ctrl)
  );
  assign {PCout, ZLowout, MDRout, Cout, MARin, MDRin, IRin, PCin, Yin, Zin, IncPC, Read, Write,
          Gra, Grb, Grc, Rin, Rout, BAout, w_alu_op, run} = w_ctrl;
  assign alu_op = ALUW'(w_alu_op);
endmodule
